// File: rtl/data_path.sv
// Datapath half of the processor: IR, PC, 4x16 register file, ALU and flags.
// It executes the control strobes and returns the instruction decode and the flags.
package data_path_pkg;
  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNEG,
    I_BOV,
    I_BNOV,
    I_BNNEG,
    I_BNZERO,
    I_HALT
  } decoded_instruction_type;
endpackage

module data_path
  import data_path_pkg::*;
#(
  parameter logic [4:0]  PC_RESET  = 5'd0,
  parameter logic [15:0] REG_RESET = 16'd0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    flags_reg_enable,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [4:0]              ram_addr,
  output logic [15:0]             data_out,
  input  logic [15:0]             data_in
);

  logic [15:0] ir_q, ir_d;
  logic [4:0]  pc_q, pc_d;
  logic [15:0] regs_q [4];
  logic [15:0] regs_d [4];
  logic [3:0]  flags_q, flags_d;  // {zero, neg, uov, sov}

  decoded_instruction_type dec;
  logic [1:0]  wr_idx, a_idx, b_idx;
  logic [15:0] op_a, op_b, alu_res, wb_data;
  logic [16:0] sum_ext, diff_ext;
  logic        alu_uov, alu_sov;

  // ---------------------------------------------------------------- decode
  always_comb begin
    dec = I_NOP;
    case (ir_q[15:8])
      8'h00:   dec = I_NOP;
      8'h81:   dec = I_LOAD;
      8'h82:   dec = I_STORE;
      8'h91:   dec = I_MOVE;
      8'hA1:   dec = I_ADD;
      8'hA2:   dec = I_SUB;
      8'hA3:   dec = I_AND;
      8'hA4:   dec = I_OR;
      8'h01:   dec = I_BRANCH;
      8'h02:   dec = I_BZERO;
      8'h03:   dec = I_BNEG;
      8'h05:   dec = I_BOV;
      8'h06:   dec = I_BNOV;
      8'h0A:   dec = I_BNNEG;
      8'h0B:   dec = I_BNZERO;
      8'hFF:   dec = I_HALT;
      default: dec = I_NOP;
    endcase
  end

  assign decoded_instruction = dec;

  // Register fields move around by instruction class; MOVE reuses B as A so OR copies.
  always_comb begin
    wr_idx = ir_q[5:4];
    a_idx  = ir_q[3:2];
    b_idx  = ir_q[1:0];
    case (dec)
      I_LOAD: wr_idx = ir_q[6:5];
      I_MOVE: begin
        wr_idx = ir_q[3:2];
        a_idx  = ir_q[1:0];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- ALU
  assign op_a     = regs_q[a_idx];
  assign op_b     = regs_q[b_idx];
  assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_ext = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    alu_res = 16'h0000;
    alu_uov = 1'b0;
    alu_sov = 1'b0;
    case (operation)
      2'b00: alu_res = op_a | op_b;
      2'b01: begin
        alu_res = sum_ext[15:0];
        alu_uov = sum_ext[16];
        alu_sov = (op_a[15] == op_b[15]) && (alu_res[15] != op_a[15]);
      end
      2'b10: begin
        // Bit 16 of the zero-extended difference is the borrow (A < B unsigned).
        alu_res = diff_ext[15:0];
        alu_uov = diff_ext[16];
        alu_sov = (op_a[15] != op_b[15]) && (alu_res[15] != op_a[15]);
      end
      default: alu_res = op_a & op_b;
    endcase
  end

  assign wb_data = c_sel ? alu_res : data_in;

  // ---------------------------------------------------------------- next state
  always_comb begin
    ir_d    = ir_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    for (int i = 0; i < 4; i++) begin
      regs_d[i] = regs_q[i];
    end

    if (ir_enable) begin
      ir_d = data_in;
    end
    if (pc_enable) begin
      pc_d = branch ? ir_q[4:0] : pc_q + 5'd1;
    end
    if (flags_reg_enable) begin
      flags_d = {(alu_res == 16'h0000), alu_res[15], alu_uov, alu_sov};
    end
    if (write_reg_enable) begin
      regs_d[wr_idx] = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_q    <= 16'h0000;
      pc_q    <= PC_RESET;
      flags_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= REG_RESET;
      end
    end else begin
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign ram_addr          = addr_sel ? pc_q : ir_q[4:0];
  assign data_out          = regs_q[ir_q[6:5]];
  assign zero_op           = flags_q[3];
  assign neg_op            = flags_q[2];
  assign unsigned_overflow = flags_q[1];
  assign signed_overflow   = flags_q[0];

endmodule
